bk_operand_stager: RTL and testbench

//  Registered front/back end for the 12-bit combinational Brent-Kung adder.
//  - Accepts operand pairs over a valid/ready handshake.
//  - Packs them onto the adder's interleaved INPUTS bus.
//  - Waits a fixed settle time, then captures the adder's OUTS into a result register.
//  - Presents the result over a valid/ready handshake.
//  The adder is instantiated beside this block (it is not inside it); this block sits directly upstream and downstream of it.

---
 rtl/bk_pkg.sv | 28 ++
 rtl/bk_interleave.sv | 22 ++
 rtl/bk_operand_stager.sv | 209 ++++++++++++++++++++
 tb/tb_bk_operand_stager.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bk_pkg.sv
// Shared definitions for the Brent-Kung operand stager.
// Holds the default operand width, the stager state encoding and the
// reference interleave helper that maps an operand pair onto the adder bus.
package bk_pkg;

    localparam int BK_WIDTH = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } bk_state_e;

    // Adder INPUTS layout: even bits carry operand A, odd bits carry operand B.
    function automatic logic [2*BK_WIDTH-1:0] bk_interleave_f(
        input logic [BK_WIDTH-1:0] a,
        input logic [BK_WIDTH-1:0] b
    );
        logic [2*BK_WIDTH-1:0] bus;
        bus = '0;
        for (int i = 0; i < BK_WIDTH; i++) begin
            bus[2*i]   = a[i];
            bus[2*i+1] = b[i];
        end
        return bus;
    endfunction

endpackage : bk_pkg

// File: rtl/bk_interleave.sv
// Combinational packer from an operand pair onto the interleaved adder bus.
// Bit 2i of the bus carries a[i], bit 2i+1 carries b[i].
module bk_interleave
    import bk_pkg::*;
#(
    parameter int WIDTH = BK_WIDTH
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] bus
);

    // Scatter the two operands onto alternating bus lanes.
    always_comb begin
        bus = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bus[2*i]   = a[i];
            bus[2*i+1] = b[i];
        end
    end

endmodule : bk_interleave

// File: rtl/bk_operand_stager.sv
// Registered front/back end wrapped around an external combinational
// Brent-Kung adder. Operands arrive over valid/ready, are packed onto the
// adder's interleaved INPUTS bus, held for SETTLE_CYC cycles, and the
// adder's OUTS are then captured and offered downstream over valid/ready.
//
// Optional build macro: BK_STAGER_CHECK_EN
//   defined   - a shadow adder recomputes a+b from the captured operands and
//               any disagreement with add_outs at the sample cycle sets the
//               sticky mismatch_err flag (cleared only by rst).
//   undefined - mismatch_err is tied low and no shadow logic is built.
module bk_operand_stager
    import bk_pkg::*;
#(
    parameter int WIDTH      = BK_WIDTH,
    parameter int SETTLE_CYC = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic [2*WIDTH-1:0] add_inputs,
    input  logic [WIDTH:0]     add_outs,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH:0]     out_sum,
    output logic               mismatch_err
);

    // Counter only needs to hold SETTLE_CYC; guard the width for illegal values
    // so the elaboration error below is the only complaint.
    localparam int               CNT_W    = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    generate
        if (SETTLE_CYC < 1) begin : g_bad_settle
            $error("bk_operand_stager: SETTLE_CYC must be at least 1");
        end
    endgenerate

    bk_state_e          state_q;
    bk_state_e          state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [2*WIDTH-1:0] add_inputs_q;
    logic [2*WIDTH-1:0] add_inputs_d;
    logic               out_valid_q;
    logic               out_valid_d;
    logic [WIDTH:0]     out_sum_q;
    logic [WIDTH:0]     out_sum_d;

    logic [2*WIDTH-1:0] packed_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               sample_s;

    bk_interleave #(
        .WIDTH (WIDTH)
    ) u_pack (
        .a   (in_a),
        .b   (in_b),
        .bus (packed_s)
    );

    // Ready is open in IDLE, follows the consumer in HOLD, and is held low
    // during reset so nothing is accepted on a reset edge.
    always_comb begin
        in_ready_s = 1'b0;
        if (rst) begin
            in_ready_s = 1'b0;
        end else begin
            case (state_q)
                IDLE:    in_ready_s = 1'b1;
                HOLD:    in_ready_s = out_ready;
                default: in_ready_s = 1'b0;
            endcase
        end
    end

    assign accept_s = in_valid & in_ready_s;

    // The last settle cycle is the one in which add_outs is captured.
    assign sample_s = (state_q == SETTLE) && (cnt_q == CNT_ONE);

    // Next-state and datapath updates for the IDLE -> SETTLE -> HOLD sequence.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        add_inputs_d = add_inputs_q;
        out_valid_d  = out_valid_q;
        out_sum_d    = out_sum_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d      = SETTLE;
                    cnt_d        = CNT_LOAD;
                    add_inputs_d = packed_s;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (sample_s) begin
                    state_d     = HOLD;
                    cnt_d       = '0;
                    out_sum_d   = add_outs;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    // Result is consumed; a waiting operand pair is taken in
                    // the same cycle so back-to-back traffic has no bubble.
                    out_valid_d = 1'b0;
                    if (accept_s) begin
                        state_d      = SETTLE;
                        cnt_d        = CNT_LOAD;
                        add_inputs_d = packed_s;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State, counter and all registered outputs of the stager.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            add_inputs_q <= '0;
            out_valid_q  <= 1'b0;
            out_sum_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            add_inputs_q <= add_inputs_d;
            out_valid_q  <= out_valid_d;
            out_sum_q    <= out_sum_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign add_inputs = add_inputs_q;
    assign out_valid  = out_valid_q;
    assign out_sum    = out_sum_q;

`ifdef BK_STAGER_CHECK_EN
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_a_d;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] op_b_d;
    logic [WIDTH:0]   shadow_sum_s;
    logic             mismatch_q;
    logic             mismatch_d;

    // Keep a plain copy of the accepted operands for the shadow adder.
    always_comb begin
        if (accept_s) begin
            op_a_d = in_a;
            op_b_d = in_b;
        end else begin
            op_a_d = op_a_q;
            op_b_d = op_b_q;
        end
    end

    assign shadow_sum_s = {1'b0, op_a_q} + {1'b0, op_b_q};

    // Flag any disagreement at the capture cycle; the flag never self-clears.
    always_comb begin
        if (sample_s && (shadow_sum_s != add_outs)) begin
            mismatch_d = 1'b1;
        end else begin
            mismatch_d = mismatch_q;
        end
    end

    // Shadow operand copy and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_q     <= '0;
            op_b_q     <= '0;
            mismatch_q <= 1'b0;
        end else begin
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch_err = mismatch_q;
`else
    assign mismatch_err = 1'b0;
`endif

endmodule : bk_operand_stager

// File: tb/tb_bk_operand_stager.sv
// Self-checking bench for bk_operand_stager.
// Two instances: dut1 with SETTLE_CYC=1 and dut3 with SETTLE_CYC=3, each with
// a behavioural adder attached to its interleaved bus. Expected sums are
// queued when operands are handed over and compared when results are consumed.
module tb_bk_operand_stager;

    logic        clk;
    logic        rst;

    logic        in_valid1, in_ready1, out_valid1, out_ready1, err1;
    logic [11:0] in_a1, in_b1;
    logic [23:0] add_inputs1;
    logic [12:0] add_outs1, out_sum1;

    logic        in_valid3, in_ready3, out_valid3, out_ready3, err3;
    logic [11:0] in_a3, in_b3;
    logic [23:0] add_inputs3;
    logic [12:0] add_outs3, out_sum3;

    logic        corrupt;
    logic [11:0] ma1, mb1, ma3, mb3;

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;

    logic [12:0] q1[$];
    logic [12:0] q3[$];
    logic        acc3;
    int          cons3;
    int          last_cons3;

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic [12:0] sum;
    } vec_t;

    vec_t        vecs[6];
    logic [11:0] ra[8];
    logic [11:0] rb[8];

    bk_operand_stager #(.WIDTH(12), .SETTLE_CYC(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .add_inputs(add_inputs1), .add_outs(add_outs1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1),
        .mismatch_err(err1)
    );

    bk_operand_stager #(.WIDTH(12), .SETTLE_CYC(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_a(in_a3), .in_b(in_b3), .add_inputs(add_inputs3), .add_outs(add_outs3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_sum(out_sum3),
        .mismatch_err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] tb_pack(input logic [11:0] a, input logic [11:0] b);
        logic [23:0] r;
        r = '0;
        for (int i = 0; i < 12; i++) begin
            r[2*i]   = a[i];
            r[2*i+1] = b[i];
        end
        return r;
    endfunction

    function automatic logic [11:0] tb_unpack(input logic [23:0] bus, input int lane);
        logic [11:0] r;
        for (int i = 0; i < 12; i++) begin
            r[i] = bus[2*i+lane];
        end
        return r;
    endfunction

    // Behavioural adders; dut1's can be told to return a wrong sum for 1+1.
    always_comb begin
        ma1 = tb_unpack(add_inputs1, 0);
        mb1 = tb_unpack(add_inputs1, 1);
        add_outs1 = (corrupt && ma1 == 12'd1 && mb1 == 12'd1) ? 13'h123 : ({1'b0, ma1} + {1'b0, mb1});
        ma3 = tb_unpack(add_inputs3, 0);
        mb3 = tb_unpack(add_inputs3, 1);
        add_outs3 = {1'b0, ma3} + {1'b0, mb3};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sb_pop(input string name, ref logic [12:0] q[$], input logic [12:0] act);
        logic [12:0] e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got out_sum %0h with no result expected (cycle %0d)", name, act, cyc);
        end else begin
            e = q.pop_front();
            chk(name, 32'(act), 32'(e));
        end
    endtask

    // Runs at the falling edge: what it sees is what the next rising edge acts on.
    task automatic monitor();
        acc3 = 1'b0;
        if (!rst) begin
            if (out_valid1 && out_ready1) begin
                sb_pop("sb1_sum", q1, out_sum1);
            end
            if (in_valid3 && in_ready3) begin
                q3.push_back({1'b0, in_a3} + {1'b0, in_b3});
                acc3 = 1'b1;
            end
            if (out_valid3 && out_ready3) begin
                sb_pop("sb3_sum", q3, out_sum3);
                if (cons3 > 0) begin
                    chk("t4_period", 32'(cyc - last_cons3), 32'd4);
                end
                if (in_valid3) begin
                    chk("t4_accept_with_consume", 32'(in_ready3), 32'd1);
                end
                last_cons3 = cyc;
                cons3++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // One isolated transaction on dut1 with full latency checks.
    task automatic op1(input string tag, input logic [11:0] a, input logic [11:0] b,
                       input logic [12:0] exp);
        in_a1 = a; in_b1 = b; in_valid1 = 1'b1; out_ready1 = 1'b1;
        q1.push_back(exp);
        tick();
        in_valid1 = 1'b0;
        chk({tag, "_add_inputs_c1"}, 32'(add_inputs1), 32'(tb_pack(a, b)));
        chk({tag, "_valid_low_c1"}, 32'(out_valid1), 32'd0);
        tick();
        chk({tag, "_valid_c2"}, 32'(out_valid1), 32'd1);
        chk({tag, "_sum_c2"}, 32'(out_sum1), 32'(exp));
        tick();
        chk({tag, "_idle_after"}, 32'(out_valid1), 32'd0);
    endtask

    initial begin
        rst = 1'b1; corrupt = 1'b0;
        in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; out_ready1 = 1'b0;
        in_valid3 = 1'b0; in_a3 = '0; in_b3 = '0; out_ready3 = 1'b0;
        acc3 = 1'b0; cons3 = 0; last_cons3 = 0;

        vecs[0] = '{a: 12'hFFF, b: 12'h001, sum: 13'h1000};
        vecs[1] = '{a: 12'h123, b: 12'h456, sum: 13'h0579};
        vecs[2] = '{a: 12'hFFF, b: 12'hFFF, sum: 13'h1FFE};
        vecs[3] = '{a: 12'h000, b: 12'h000, sum: 13'h0000};
        vecs[4] = '{a: 12'h555, b: 12'hAAA, sum: 13'h0FFF};
        vecs[5] = '{a: 12'h800, b: 12'h7FF, sum: 13'h0FFF};
        for (int i = 0; i < 8; i++) begin
            ra[i] = 12'($urandom_range(4095, 0));
            rb[i] = 12'($urandom_range(4095, 0));
        end

        // 1. Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_in_ready1", 32'(in_ready1), 32'd0);
            chk("rst_in_ready3", 32'(in_ready3), 32'd0);
            chk("rst_out_valid", 32'(out_valid1), 32'd0);
            chk("rst_add_inputs", 32'(add_inputs1), 32'd0);
            chk("rst_out_sum", 32'(out_sum1), 32'd0);
            chk("rst_err", 32'(err1), 32'd0);
        end
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready1", 32'(in_ready1), 32'd1);
        chk("post_rst_in_ready3", 32'(in_ready3), 32'd1);

        // 2. Table of isolated operand pairs, first one is the carry-out case.
        for (int i = 0; i < 6; i++) begin
            op1($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sum);
        end

        // 3. Back-pressure: result and operands held while out_ready is low.
        in_a1 = 12'h123; in_b1 = 12'h456; in_valid1 = 1'b1; out_ready1 = 1'b0;
        q1.push_back(13'h0579);
        tick();
        in_valid1 = 1'b0;
        tick();
        in_a1 = 12'h00A; in_b1 = 12'h00B; in_valid1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 32'(out_valid1), 32'd1);
            chk("bp_out_sum", 32'(out_sum1), 32'h579);
            chk("bp_in_ready", 32'(in_ready1), 32'd0);
            chk("bp_add_inputs", 32'(add_inputs1), 32'(tb_pack(12'h123, 12'h456)));
            tick();
        end
        out_ready1 = 1'b1;
        #1;
        chk("bp_in_ready_follows", 32'(in_ready1), 32'd1);
        q1.push_back(13'h0015);
        tick();
        in_valid1 = 1'b0;
        chk("bp2_add_inputs", 32'(add_inputs1), 32'(tb_pack(12'h00A, 12'h00B)));
        chk("bp2_valid_low", 32'(out_valid1), 32'd0);
        tick();
        chk("bp2_valid", 32'(out_valid1), 32'd1);
        chk("bp2_sum", 32'(out_sum1), 32'h015);
        tick();

        // 4. Streaming on dut3 with in_valid and out_ready held high.
        in_a3 = ra[0]; in_b3 = rb[0]; in_valid3 = 1'b1; out_ready3 = 1'b1;
        begin
            int idx;
            idx = 0;
            for (int n = 0; n < 80 && cons3 < 8; n++) begin
                tick();
                if (acc3) begin
                    idx++;
                    if (idx < 8) begin
                        in_a3 = ra[idx]; in_b3 = rb[idx];
                    end else begin
                        in_valid3 = 1'b0;
                    end
                end
            end
        end
        chk("t4_results_seen", 32'(cons3), 32'd8);

        // 5. Reset pulse while dut1 is settling drops the transaction.
        in_a1 = 12'h800; in_b1 = 12'h800; in_valid1 = 1'b1; out_ready1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        chk("t5_settle_no_valid", 32'(out_valid1), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_add_inputs_cleared", 32'(add_inputs1), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("t5_no_out_valid", 32'(out_valid1), 32'd0);
            tick();
        end
        op1("t5_next", 12'h001, 12'h002, 13'h0003);

        // 6. Faulty adder answer for 1+1 on dut1.
        corrupt = 1'b1;
        in_a1 = 12'h001; in_b1 = 12'h001; in_valid1 = 1'b1; out_ready1 = 1'b1;
        q1.push_back(13'h0123);
        tick();
        in_valid1 = 1'b0;
        chk("t6_err_before_sample", 32'(err1), 32'd0);
        tick();
        chk("t6_captured_bad_sum", 32'(out_sum1), 32'h123);
`ifdef BK_STAGER_CHECK_EN
        chk("t6_err_set", 32'(err1), 32'd1);
        tick();
        corrupt = 1'b0;
        op1("t6_good", 12'h005, 12'h006, 13'h000B);
        chk("t6_err_sticky", 32'(err1), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_err_cleared", 32'(err1), 32'd0);
`else
        chk("t6_err_tied_low", 32'(err1), 32'd0);
        tick();
        corrupt = 1'b0;
        chk("t6_err_still_low", 32'(err1), 32'd0);
`endif
        chk("err3_low", 32'(err3), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q3_drained", 32'(q3.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_bk_operand_stager
